dmem_responder: RTL and testbench

Multi-cycle data-memory responder serving load/store requests issued by the pipelined CPU's MEM stage over a valid/ready request channel and a one-cycle response pulse. Holds a word-addressed storage array and returns read data or completes writes after a configurable latency. Drives a stall signal so the pipeline can freeze its PC, IF/ID, ID/EX and EX/MEM registers until the access completes.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

  localparam int LAT_W  = 4;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed register array: one synchronous write port, one
// combinational read port, every word cleared by the async reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Storage: clear on reset, otherwise commit one word when write-enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, spends
// LATENCY cycles busy, then pulses a response while freezing the CPU
// pipeline through stall.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall
);

  localparam int AW = $clog2(DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LAT_W-1:0]  r_cnt;
  logic              r_write;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_resp_rdata;
  logic              r_resp_err;

  logic              w_accept;
  logic              w_access;
  logic              w_err;
  logic              w_we;
  logic [AW-1:0]     w_idx;
  logic [WORD_W-1:0] w_arr_rdata;

  // Decode the latched address; anything past the array or not word
  // aligned is an error and must never touch storage (the index would alias).
  assign w_idx = r_addr[AW+1:2];
  assign w_err = (r_addr[1:0] != 2'b00) ||
                 ({2'b00, r_addr[31:2]} >= WORD_W'(DEPTH));
  assign w_we  = w_access & r_write & ~w_err;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_we    (w_we),
    .i_waddr (w_idx),
    .i_wdata (r_wdata),
    .i_raddr (w_idx),
    .o_rdata (w_arr_rdata)
  );

  // Next-state, handshake and stall decode; stall drops in RESP so the
  // pipeline advances on the same edge that completes the access.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    stall       = 1'b0;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (r_cnt == '0) begin
          w_access    = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Latency counter and registered response fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept)                           r_cnt <= LAT_W'(LATENCY - 1);
      else if (r_state == BUSY && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_access) begin
        r_resp_err   <= w_err;
        r_resp_rdata <= w_err ? '0 : (r_write ? r_wdata : w_arr_rdata);
      end
    end
  end

  // Request capture; BUSY ignores the request inputs because only an
  // accepted handshake loads these.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against
// a word-array reference model, and a LATENCY=1 instance for timing.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_err, b_stall;
  logic [31:0] b_resp_rdata;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model [DEPTH];
  bit          in_resp;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .stall(b_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference: what a single access returns and how it changes memory.
  function automatic void ref_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                                     output logic [31:0] rd, output bit err);
    err = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    if (err)    rd = '0;
    else if (w) begin model[a >> 2] = d; rd = d; end
    else        rd = model[a >> 2];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endfunction

  // Entered at a negedge with the DUT in IDLE or RESP; returns at the
  // negedge where this access's response is visible.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit scramble, input string tag);
    int          n;
    logic [31:0] erd;
    bit          eerr;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    #1;
    chk({tag, ".ready"}, req_ready, 1);
    chk({tag, ".stall_req"}, stall, in_resp ? 0 : 1);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_valid = 1'b0;
        if (scramble) begin
          req_addr = $urandom; req_wdata = $urandom; req_write = ~w;
        end
      end
      if (!resp_valid) chk({tag, ".stall_busy"}, stall, 1);
    end while (!resp_valid && n < 32);
    chk({tag, ".latency"}, n, LAT + 1);
    ref_access(w, a, d, erd, eerr);
    chk({tag, ".rdata"}, resp_rdata, erd);
    chk({tag, ".err"}, resp_err, eerr);
    chk({tag, ".stall_resp"}, stall, 0);
    in_resp = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
    in_resp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d;
    bit          w;
    int          kind;

    reset = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0;
    model_clear();
    in_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.resp_valid", resp_valid, 0);
    chk("rst.rdata", resp_rdata, 0);
    chk("rst.err", resp_err, 0);
    chk("rst.ready", req_ready, 1);
    chk("rst.stall", stall, 0);
    reset = 1'b1;
    @(negedge clk);

    // Store then load back.
    issue(1, 32'h10, 32'hDEADBEEF, 0, "st10");
    gap(1);
    issue(0, 32'h10, 0, 0, "ld10");
    chk("ld10.const", resp_rdata, 32'hDEADBEEF);

    // Back-to-back: load presented in the store's RESP cycle.
    gap(1);
    issue(1, 32'h4, 32'h1234, 0, "st4");
    issue(0, 32'h4, 0, 0, "ld4_b2b");
    chk("ld4.const", resp_rdata, 32'h00001234);

    // Errors: misaligned load, out-of-range store that would alias word 0.
    gap(1);
    issue(1, 32'h0, 32'hCAFE0000, 0, "st0");
    gap(1);
    issue(0, 32'h6, 0, 0, "ld6_mis");
    chk("ld6.err_const", resp_err, 1);
    issue(1, 32'h100, 32'hFFFFFFFF, 0, "st100_oor");
    chk("st100.rdata_const", resp_rdata, 0);
    gap(2);
    issue(0, 32'h0, 0, 0, "ld0_after_err");
    chk("ld0.const", resp_rdata, 32'hCAFE0000);

    // Inputs changed while BUSY must not affect the access.
    gap(1);
    issue(1, 32'h20, 32'h11112222, 1, "st20_hold");
    gap(1);
    issue(0, 32'h20, 0, 1, "ld20_hold");
    chk("ld20.const", resp_rdata, 32'h11112222);

    // Reset mid-BUSY store.
    gap(1);
    issue(1, 32'h8, 32'h77777777, 0, "st8");
    gap(1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rstb.resp_valid", resp_valid, 0);
    chk("rstb.rdata", resp_rdata, 0);
    chk("rstb.err", resp_err, 0);
    chk("rstb.ready", req_ready, 1);
    chk("rstb.stall", stall, 0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    gap(1);
    issue(0, 32'h8, 0, 0, "ld8_after_rst");
    chk("ld8.const", resp_rdata, 0);

    // Random traffic.
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 9);
      w    = $urandom_range(0, 1);
      d    = $urandom;
      if (kind == 0)      a = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3);
      else if (kind == 1) a = ($urandom | 32'h100) & ~32'h3;
      else                a = $urandom_range(0, DEPTH - 1) << 2;
      if ($urandom_range(0, 2) != 0) gap($urandom_range(1, 3));
      issue(w, a, d, ($urandom_range(0, 3) == 0), "rnd");
    end
    gap(2);

    // LATENCY=1 instance: store then back-to-back load.
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'hC; b_req_wdata = 32'hA5A5A5A5;
    #1;
    chk("l1.st.stall_req", b_stall, 1);
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("l1.st.busy_valid", b_resp_valid, 0);
    chk("l1.st.busy_stall", b_stall, 1);
    @(negedge clk);
    chk("l1.st.resp_valid", b_resp_valid, 1);
    chk("l1.st.rdata", b_resp_rdata, 32'hA5A5A5A5);
    chk("l1.st.err", b_resp_err, 0);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_wdata = 32'h0;
    #1;
    chk("l1.ld.ready", b_req_ready, 1);
    chk("l1.ld.stall_resp", b_stall, 0);
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("l1.ld.busy_valid", b_resp_valid, 0);
    chk("l1.ld.busy_stall", b_stall, 1);
    @(negedge clk);
    chk("l1.ld.resp_valid", b_resp_valid, 1);
    chk("l1.ld.rdata", b_resp_rdata, 32'hA5A5A5A5);
    chk("l1.ld.stall_resp2", b_stall, 0);
    @(negedge clk);
    chk("l1.idle.valid", b_resp_valid, 0);
    chk("l1.idle.stall", b_stall, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
